uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rx_if.sv | 15 +
 rtl/uart_baud_cnt.sv | 34 +++
 rtl/uart_rx.sv | 160 ++++++++++++++++
 tb/tb_uart_rx.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the receiver and the transmitter.
//   uart_state_e : frame state encoding. PARITY exists only when
//                  UART_RX_PARITY_EN is defined.
//   uart_div     : clock cycles per bit (integer division).
//   uart_mid     : counter value at which a bit is sampled.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } uart_state_e;

    function automatic int uart_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    function automatic int uart_mid(input int div);
        return div / 2;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// User-side bundle of the UART receiver: received data plus its one-cycle
// valid / frame-error / parity-error pulses.
//   master : the receiver side (drives everything)
//   slave  : the consumer side (observes everything, no backpressure)
interface uart_rx_if #(
    parameter int DW = 8
) ();
    logic [DW-1:0] data;
    logic          valid;
    logic          frame_err;
    logic          parity_err;

    modport master (output data, valid, frame_err, parity_err);
    modport slave  (input  data, valid, frame_err, parity_err);
endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter, shared by the receiver and the transmitter.
// Counts 0..P_DIV-1 and wraps, so mid strobes recur once per bit.
//   clk, rst : clock, async active-high reset
//   load     : clear the count (bit timing restarts from 0)
//   mid      : one-cycle strobe at count P_DIV/2
//   bit_end  : one-cycle strobe at count P_DIV-1
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int P_DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic mid,
    output logic bit_end
);
    localparam int MID = uart_mid(P_DIV);
    localparam int CW  = (P_DIV > 2) ? $clog2(P_DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load || bit_end)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign mid     = (cnt == CW'(MID));
    assign bit_end = (cnt == CW'(P_DIV - 1));
endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, P_UART_DATAWIDTH data bits LSB first, optional even
// parity bit (macro UART_RX_PARITY_EN), P_UART_STOPWIDTH stop bits.
//   i_clk, i_rst    : clock, async active-high reset
//   i_uart_rx       : serial line (asynchronous, idle high)
//   o_user_rx_data  : last good frame's data, held until the next good frame
//   o_user_rx_valid : one-cycle pulse on a good frame
//   o_rx_frame_err  : one-cycle pulse on a low stop bit
//   o_rx_parity_err : one-cycle pulse on parity mismatch (0 without parity)
module uart_rx
    import uart_pkg::*;
#(
    parameter int P_SYSTEM_CLK     = 50_000_000,
    parameter int P_UART_BUADRATE  = 9600,
    parameter int P_UART_DATAWIDTH = 8,
    parameter int P_UART_STOPWIDTH = 1
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_uart_rx,
    output logic [P_UART_DATAWIDTH-1:0] o_user_rx_data,
    output logic                        o_user_rx_valid,
    output logic                        o_rx_frame_err,
    output logic                        o_rx_parity_err
);
    localparam int DIV = uart_div(P_SYSTEM_CLK, P_UART_BUADRATE);
    localparam int BW  = (P_UART_DATAWIDTH > 1) ? $clog2(P_UART_DATAWIDTH) : 1;

    // rx_meta/rx_sync form the synchronizer; rx_prev only delays rx_sync
    // for edge detection. All reset high so reset never looks like a start.
    // A line left low after a frame error keeps rx_prev low, so no new
    // start is seen until the line has returned high.
    logic rx_meta, rx_sync, rx_prev, fall;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= i_uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign fall = rx_prev & ~rx_sync;

    logic baud_load, baud_mid, baud_end_unused;

    // The end strobe serves the transmitter; the receiver works on mid only.
    uart_baud_cnt #(.P_DIV(DIV)) u_baud (
        .clk     (i_clk),
        .rst     (i_rst),
        .load    (baud_load),
        .mid     (baud_mid),
        .bit_end (baud_end_unused)
    );

    uart_state_e                 state, state_nxt;
    logic [P_UART_DATAWIDTH-1:0] shreg;
    logic [BW-1:0]               bit_idx;
    logic                        stop_idx, frame_bad, stop_bad_now;
    logic                        data_last, stop_last, parity_flag;

    assign data_last    = (bit_idx == BW'(P_UART_DATAWIDTH - 1));
    assign stop_last    = (stop_idx == 1'(P_UART_STOPWIDTH - 1));
    assign stop_bad_now = frame_bad | ~rx_sync;

`ifdef UART_RX_PARITY_EN
    logic parity_bad;
    assign parity_flag = parity_bad;
`else
    assign parity_flag     = 1'b0;
    assign o_rx_parity_err = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        baud_load = 1'b0;
        case (state)
            IDLE: begin
                // Counter held at 0 so bit timing starts at the edge.
                baud_load = 1'b1;
                if (fall) state_nxt = START;
            end
            START:  if (baud_mid) state_nxt = rx_sync ? IDLE : DATA;
            DATA:   if (baud_mid && data_last)
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
            PARITY: if (baud_mid) state_nxt = STOP;
`else
                        state_nxt = STOP;
`endif
            // Leave at the mid sample so the next start edge is not missed.
            STOP:   if (baud_mid && stop_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            shreg           <= '0;
            bit_idx         <= '0;
            stop_idx        <= 1'b0;
            frame_bad       <= 1'b0;
            o_user_rx_data  <= '0;
            o_user_rx_valid <= 1'b0;
            o_rx_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad      <= 1'b0;
            o_rx_parity_err <= 1'b0;
`endif
        end else begin
            o_user_rx_valid <= 1'b0;
            o_rx_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            o_rx_parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    bit_idx   <= '0;
                    stop_idx  <= 1'b0;
                    frame_bad <= 1'b0;
`ifdef UART_RX_PARITY_EN
                    parity_bad <= 1'b0;
`endif
                end
                DATA: if (baud_mid) begin
                    shreg   <= {rx_sync, shreg[P_UART_DATAWIDTH-1:1]};
                    bit_idx <= bit_idx + 1'b1;
                end
`ifdef UART_RX_PARITY_EN
                // Even parity: data bits plus parity bit hold an even count of 1s.
                PARITY: if (baud_mid) parity_bad <= (rx_sync != ^shreg);
`endif
                STOP: if (baud_mid) begin
                    stop_idx  <= stop_idx + 1'b1;
                    frame_bad <= stop_bad_now;
                    if (stop_last) begin
                        if (!stop_bad_now && !parity_flag) begin
                            o_user_rx_data  <= shreg;
                            o_user_rx_valid <= 1'b1;
                        end else begin
                            o_rx_frame_err  <= stop_bad_now;
`ifdef UART_RX_PARITY_EN
                            o_rx_parity_err <= parity_bad;
`endif
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx. A small clock/baud ratio keeps frames
// short; expected frame outcomes are queued as frames are sent and a monitor
// pops and compares them whenever the receiver pulses an output.
module tb_uart_rx;
    localparam int CLK_HZ = 170;
    localparam int BAUD   = 10;
    localparam int DIV    = CLK_HZ / BAUD;   // 17 cycles per bit
    localparam int DW     = 8;
    localparam int SW     = 1;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic line = 1'b1;

    uart_rx_if #(.DW(DW)) rx_if ();

    uart_rx #(
        .P_SYSTEM_CLK    (CLK_HZ),
        .P_UART_BUADRATE (BAUD),
        .P_UART_DATAWIDTH(DW),
        .P_UART_STOPWIDTH(SW)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_uart_rx      (line),
        .o_user_rx_data (rx_if.data),
        .o_user_rx_valid(rx_if.valid),
        .o_rx_frame_err (rx_if.frame_err),
        .o_rx_parity_err(rx_if.parity_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          valid;
        logic          ferr;
        logic          perr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] model_data = '0;   // what o_user_rx_data should hold

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, want);
        end
    endtask

    // Monitor: every output pulse must match the oldest outstanding frame.
    always @(negedge clk) begin
        if (rx_if.valid || rx_if.frame_err || rx_if.parity_err) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output v=%0b fe=%0b pe=%0b data=%02h, no frame outstanding",
                         rx_if.valid, rx_if.frame_err, rx_if.parity_err, rx_if.data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({rx_if.valid, rx_if.frame_err, rx_if.parity_err} !== {e.valid, e.ferr, e.perr} ||
                    rx_if.data !== e.data) begin
                    failures++;
                    $display("FAIL frame_out got v=%0b fe=%0b pe=%0b data=%02h expected v=%0b fe=%0b pe=%0b data=%02h",
                             rx_if.valid, rx_if.frame_err, rx_if.parity_err, rx_if.data,
                             e.valid, e.ferr, e.perr, e.data);
                end
            end
        end
    end

    task automatic bit_period(input logic v);
        line = v;
        repeat (DIV) @(negedge clk);
    endtask

    task automatic idle(input int cycles);
        line = 1'b1;
        repeat (cycles) @(negedge clk);
    endtask

    // Sends one frame and queues its expected outcome. A bad stop drives
    // every stop bit low; the line is left at the last stop level.
    task automatic send_frame(input logic [DW-1:0] d, input logic stop_ok, input logic par_ok);
        exp_t e;
        logic par_eff;
`ifdef UART_RX_PARITY_EN
        par_eff = par_ok;
`else
        par_eff = 1'b1;
        if (par_ok) ;   // no parity bit in this build
`endif
        e.valid = stop_ok && par_eff;
        e.ferr  = !stop_ok;
        e.perr  = !par_eff;
        if (e.valid) model_data = d;
        e.data  = model_data;
        exp_q.push_back(e);

        bit_period(1'b0);
        for (int i = 0; i < DW; i++) bit_period(d[i]);
`ifdef UART_RX_PARITY_EN
        bit_period((^d) ^ !par_ok);
`endif
        for (int s = 0; s < SW; s++) bit_period(stop_ok);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_data"},  32'(rx_if.data),       32'h0);
        chk({tag, "_valid"}, 32'(rx_if.valid),      32'h0);
        chk({tag, "_ferr"},  32'(rx_if.frame_err),  32'h0);
        chk({tag, "_perr"},  32'(rx_if.parity_err), 32'h0);
    endtask

    initial begin
        logic [DW-1:0] d;
        logic          s_ok, p_ok;
        int            gap;

        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        idle(2 * DIV);

        // Plain good frame.
        send_frame(8'hA5, 1'b1, 1'b1);
        idle(DIV);

        // Short low glitch is rejected at the start-bit mid sample.
        line = 1'b0;
        repeat (6) @(negedge clk);
        idle(3 * DIV);
        send_frame(8'h3C, 1'b1, 1'b1);
        idle(DIV);

        // Bad stop bit, then a break: no frame may start until line goes high.
        send_frame(8'h5A, 1'b0, 1'b1);
        line = 1'b0;
        repeat (3 * DIV) @(negedge clk);
        idle(DIV);
        send_frame(8'h11, 1'b1, 1'b1);
        idle(DIV);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h01, 1'b1, 1'b0);
        idle(DIV);
`endif

        // Back-to-back frames, no idle between them.
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        idle(DIV);
        chk("queue_before_reset", 32'(exp_q.size()), 32'h0);

        // Reset in the middle of data bit 4 of a frame.
        d = 8'h96;
        bit_period(1'b0);
        for (int i = 0; i < 4; i++) bit_period(d[i]);
        line = d[4];
        repeat (DIV / 2) @(negedge clk);
        rst = 1'b1;
        #1;
        check_outputs_zero("midframe_reset");
        line = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_data = '0;
        idle(2 * DIV);
        send_frame(8'hFF, 1'b1, 1'b1);
        idle(DIV);

        // Random traffic with occasional stop/parity faults and random gaps.
        for (int n = 0; n < 40; n++) begin
            d    = DW'($urandom);
            s_ok = ($urandom_range(0, 4) != 0);
            p_ok = ($urandom_range(0, 4) != 0);
            gap  = $urandom_range(0, 2 * DIV);
            send_frame(d, s_ok, p_ok);
            idle(s_ok ? gap : gap + DIV);
        end

        for (int i = 0; i < 4 * DIV && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_queue_empty", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
